// File: rtl/mux_n_reg_pkg.sv
// Shared constants and helpers for the N-channel registered mux.
// Mode encodings plus a clog2 used to validate the select width.
package mux_n_reg_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_n_reg_rr_pick.sv
// Round-robin priority search: first valid channel at or after ptr,
// wrapping at N_CH rather than at the index width.
module mux_n_reg_rr_pick #(
  parameter int N_CH        = 4,
  parameter int SIZE_SELECT = 2
) (
  input  logic [N_CH-1:0]        i_valid,
  input  logic [SIZE_SELECT-1:0] i_ptr,
  output logic                   o_found,
  output logic [SIZE_SELECT-1:0] o_idx
);

  logic [SIZE_SELECT:0] cand;
  logic                 hit;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    cand    = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, i_ptr} + (SIZE_SELECT+1)'(i);
      if (cand >= (SIZE_SELECT+1)'(N_CH))
        cand = cand - (SIZE_SELECT+1)'(N_CH);
      hit = 1'b0;
      for (int j = 0; j < N_CH; j++) begin
        if (cand == (SIZE_SELECT+1)'(j))
          hit = i_valid[j];
      end
      if (!o_found && hit) begin
        o_found = 1'b1;
        o_idx   = cand[SIZE_SELECT-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// N-channel registered mux with explicit or round-robin select.
// Optional MUX_N_REG_SEL_ERR_EN adds the sticky o_sel_err flag.
module mux_n_reg
  import mux_n_reg_pkg::*;
#(
  parameter int SIZE        = 32,
  parameter int N_CH        = 4,
  parameter int SIZE_SELECT = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_flush,
  input  logic                   i_MODE,
  input  logic [SIZE_SELECT-1:0] i_SEL,
  input  logic [N_CH*SIZE-1:0]   i_data,
  input  logic [N_CH-1:0]        i_valid,
  output logic [N_CH-1:0]        o_ready,
  output logic [SIZE-1:0]        o_data,
  output logic [SIZE_SELECT-1:0] o_chan,
  output logic                   o_valid,
  input  logic                   i_ready
`ifdef MUX_N_REG_SEL_ERR_EN
  ,
  output logic                   o_sel_err
`endif
);

  if (N_CH < 2 || N_CH > 16 ||
      SIZE_SELECT < clog2(N_CH)) begin : g_param_err
    $error("mux_n_reg: bad N_CH/SIZE_SELECT");
  end

  logic                   load;
  logic                   sel_oob;
  logic                   have;
  logic                   found;
  logic                   accept;
  logic [SIZE_SELECT-1:0] ptr;
  logic [SIZE_SELECT-1:0] rr_idx;
  logic [SIZE_SELECT-1:0] chosen;
  logic [SIZE_SELECT-1:0] ptr_nxt;
  logic [SIZE-1:0]        pick_data;

  mux_n_reg_rr_pick #(
    .N_CH        (N_CH),
    .SIZE_SELECT (SIZE_SELECT)
  ) u_rr_pick (
    .i_valid (i_valid),
    .i_ptr   (ptr),
    .o_found (found),
    .o_idx   (rr_idx)
  );

  assign load    = ~o_valid | i_ready;
  assign sel_oob = (i_MODE == MODE_SEL) && (int'(i_SEL) >= N_CH);
  assign chosen  = (i_MODE == MODE_RR) ? rr_idx : i_SEL;
  assign have    = (i_MODE == MODE_RR) ? found : ~sel_oob;

  // o_ready is gated by reset so nothing is offered while held in reset
  always_comb begin
    o_ready   = '0;
    pick_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (chosen == SIZE_SELECT'(k)) begin
        o_ready[k] = i_reset_n & load & ~i_flush & have;
        pick_data  = i_data[k*SIZE +: SIZE];
      end
    end
  end

  assign accept  = |(o_ready & i_valid);
  assign ptr_nxt = (chosen == SIZE_SELECT'(N_CH-1)) ?
                   '0 : chosen + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data  <= '0;
      o_chan  <= '0;
      o_valid <= 1'b0;
      ptr     <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_data  <= pick_data;
      o_chan  <= chosen;
      o_valid <= 1'b1;
      if (i_MODE == MODE_RR)
        ptr <= ptr_nxt;
    end else if (load) begin
      o_valid <= 1'b0;
    end
  end

`ifdef MUX_N_REG_SEL_ERR_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      o_sel_err <= 1'b0;
    else if (i_flush)
      o_sel_err <= 1'b0;
    else if (sel_oob && load)
      o_sel_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench: a 4-channel and a 3-channel instance of mux_n_reg.
module tb_mux_n_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        a_flush, a_mode, a_ready;
  logic [1:0]  a_sel;
  logic [127:0] a_data;
  logic [3:0]  a_valid, a_o_ready;
  logic [31:0] a_o_data;
  logic [1:0]  a_o_chan;
  logic        a_o_valid;

  logic        b_flush, b_mode, b_ready;
  logic [1:0]  b_sel;
  logic [95:0] b_data;
  logic [2:0]  b_valid, b_o_ready;
  logic [31:0] b_o_data;
  logic [1:0]  b_o_chan;
  logic        b_o_valid;
`ifdef MUX_N_REG_SEL_ERR_EN
  logic        a_err, b_err;
`endif

  mux_n_reg #(.SIZE(32), .N_CH(4), .SIZE_SELECT(2)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(a_flush),
    .i_MODE(a_mode), .i_SEL(a_sel), .i_data(a_data),
    .i_valid(a_valid), .o_ready(a_o_ready), .o_data(a_o_data),
    .o_chan(a_o_chan), .o_valid(a_o_valid), .i_ready(a_ready)
`ifdef MUX_N_REG_SEL_ERR_EN
    , .o_sel_err(a_err)
`endif
  );

  mux_n_reg #(.SIZE(32), .N_CH(3), .SIZE_SELECT(2)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(b_flush),
    .i_MODE(b_mode), .i_SEL(b_sel), .i_data(b_data),
    .i_valid(b_valid), .o_ready(b_o_ready), .o_data(b_o_data),
    .o_chan(b_o_chan), .o_valid(b_o_valid), .i_ready(b_ready)
`ifdef MUX_N_REG_SEL_ERR_EN
    , .o_sel_err(b_err)
`endif
  );

  localparam logic [31:0] D0 = 32'hC0C0_0000;
  localparam logic [31:0] D1 = 32'hC1C1_0001;
  localparam logic [31:0] D2 = 32'hAAAA_0002;
  localparam logic [31:0] D3 = 32'hC3C3_0003;

  function automatic logic [31:0] dat(input int k);
    case (k)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_flush = 0; a_mode = 0; a_sel = 0; a_ready = 1;
    a_data = {D3, D2, D1, D0}; a_valid = 4'b1111;
    b_flush = 0; b_mode = 0; b_sel = 0; b_ready = 1;
    b_data = {D2, D1, D0}; b_valid = 3'b000;
    rst_n = 0;
    #12;
    tests++;
    if (a_o_valid !== 1'b0 || a_o_data !== 32'h0 ||
        a_o_chan !== 2'd0 || a_o_ready !== 4'b0) begin
      fails++;
      $display("FAIL reset_a: valid=%b data=%h chan=%0d rdy=%b want 0",
               a_o_valid, a_o_data, a_o_chan, a_o_ready);
    end
    tests++;
    if (b_o_valid !== 1'b0 || b_o_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_b: valid=%b data=%h want 0",
               b_o_valid, b_o_data);
    end
`ifdef MUX_N_REG_SEL_ERR_EN
    tests++;
    if (a_err !== 1'b0 || b_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err: a=%b b=%b want 0", a_err, b_err);
    end
`endif
    a_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_explicit_select();
    a_mode = 0; a_sel = 2; a_valid = 4'b0100; a_ready = 1;
    #1;
    tests++;
    if (a_o_ready !== 4'b0100) begin
      fails++;
      $display("FAIL sel_ready: got %b want 0100", a_o_ready);
    end
    tick();
    tests++;
    if (a_o_data !== D2 || a_o_chan !== 2'd2 || a_o_valid !== 1'b1) begin
      fails++;
      $display("FAIL sel_load: data=%h chan=%0d valid=%b want %h 2 1",
               a_o_data, a_o_chan, a_o_valid, D2);
    end
  endtask

  task automatic test_stall();
    a_ready = 0; a_sel = 1; a_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (a_o_ready !== 4'b0000) begin
        fails++;
        $display("FAIL stall_ready[%0d]: got %b want 0000", i, a_o_ready);
      end
      tick();
      tests++;
      if (a_o_data !== D2 || a_o_chan !== 2'd2 || a_o_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: data=%h chan=%0d valid=%b want %h 2 1",
                 i, a_o_data, a_o_chan, a_o_valid, D2);
      end
    end
    a_ready = 1;
    #1;
    tests++;
    if (a_o_ready !== 4'b0010) begin
      fails++;
      $display("FAIL stall_release_ready: got %b want 0010", a_o_ready);
    end
    tick();
    tests++;
    if (a_o_data !== D1 || a_o_chan !== 2'd1 || a_o_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: data=%h chan=%0d valid=%b want %h 1 1",
               a_o_data, a_o_chan, a_o_valid, D1);
    end
  endtask

  task automatic test_rr_fairness();
    int exp_all [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_odd [4] = '{1, 3, 1, 3};
    a_mode = 1; a_ready = 1; a_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (a_o_chan !== 2'(exp_all[i]) || a_o_data !== dat(exp_all[i]) ||
          a_o_valid !== 1'b1) begin
        fails++;
        $display("FAIL rr_all[%0d]: chan=%0d data=%h want %0d %h",
                 i, a_o_chan, a_o_data, exp_all[i], dat(exp_all[i]));
      end
    end
    a_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (a_o_chan !== 2'(exp_odd[i]) || a_o_data !== dat(exp_odd[i])) begin
        fails++;
        $display("FAIL rr_odd[%0d]: chan=%0d data=%h want %0d %h",
                 i, a_o_chan, a_o_data, exp_odd[i], dat(exp_odd[i]));
      end
    end
  endtask

  task automatic test_flush();
    a_valid = 4'b1111; a_ready = 1; a_flush = 1;
    #1;
    tests++;
    if (a_o_ready !== 4'b0000) begin
      fails++;
      $display("FAIL flush_ready: got %b want 0000", a_o_ready);
    end
    tick();
    tests++;
    if (a_o_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_valid: got %b want 0", a_o_valid);
    end
    a_flush = 0;
    #1;
    tests++;
    if (a_o_ready !== 4'b0001) begin
      fails++;
      $display("FAIL flush_ptr: ready=%b want 0001", a_o_ready);
    end
    tick();
    tests++;
    if (a_o_chan !== 2'd0 || a_o_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_resume: chan=%0d valid=%b want 0 1",
               a_o_chan, a_o_valid);
    end
  endtask

  task automatic test_wrap_n3();
    int exp_seq [4] = '{0, 1, 2, 0};
    b_mode = 1; b_ready = 1; b_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (b_o_chan !== 2'(exp_seq[i]) || b_o_data !== dat(exp_seq[i])) begin
        fails++;
        $display("FAIL wrap3[%0d]: chan=%0d data=%h want %0d %h",
                 i, b_o_chan, b_o_data, exp_seq[i], dat(exp_seq[i]));
      end
    end
    b_mode = 0; b_sel = 3;
    #1;
    tests++;
    if (b_o_ready !== 3'b000) begin
      fails++;
      $display("FAIL oob_ready: got %b want 000", b_o_ready);
    end
    tick();
    tests++;
    if (b_o_valid !== 1'b0 || b_o_chan !== 2'd0) begin
      fails++;
      $display("FAIL oob_drain: valid=%b chan=%0d want 0 0",
               b_o_valid, b_o_chan);
    end
`ifdef MUX_N_REG_SEL_ERR_EN
    tests++;
    if (b_err !== 1'b1) begin
      fails++;
      $display("FAIL sel_err_set: got %b want 1", b_err);
    end
`endif
    b_sel = 0;
    tick();
    tests++;
    if (b_o_chan !== 2'd0 || b_o_valid !== 1'b1 || b_o_data !== D0) begin
      fails++;
      $display("FAIL oob_recover: chan=%0d valid=%b want 0 1",
               b_o_chan, b_o_valid);
    end
`ifdef MUX_N_REG_SEL_ERR_EN
    tests++;
    if (b_err !== 1'b1) begin
      fails++;
      $display("FAIL sel_err_sticky: got %b want 1", b_err);
    end
`endif
    b_flush = 1;
    tick();
    tests++;
    if (b_o_valid !== 1'b0) begin
      fails++;
      $display("FAIL b_flush_valid: got %b want 0", b_o_valid);
    end
`ifdef MUX_N_REG_SEL_ERR_EN
    tests++;
    if (b_err !== 1'b0) begin
      fails++;
      $display("FAIL sel_err_clear: got %b want 0", b_err);
    end
`endif
    b_flush = 0; b_mode = 1;
    tick();
    tests++;
    if (b_o_chan !== 2'd1 || b_o_data !== D1) begin
      fails++;
      $display("FAIL mode_switch_ptr: chan=%0d want 1", b_o_chan);
    end
  endtask

  task automatic test_async_reset();
    a_mode = 1; a_valid = 4'b1111; a_ready = 1;
    tick();
    tests++;
    if (a_o_chan !== 2'd1 || a_o_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: chan=%0d valid=%b want 1 1",
               a_o_chan, a_o_valid);
    end
    #2;
    rst_n = 0;
    #1;
    tests++;
    if (a_o_valid !== 1'b0 || a_o_data !== 32'h0 || a_o_ready !== 4'b0) begin
      fails++;
      $display("FAIL async_reset: valid=%b data=%h rdy=%b want 0 0 0",
               a_o_valid, a_o_data, a_o_ready);
    end
    #1;
    rst_n = 1;
    tick();
    tests++;
    if (a_o_chan !== 2'd0 || a_o_data !== D0 || a_o_valid !== 1'b1) begin
      fails++;
      $display("FAIL rr_restart: chan=%0d data=%h want 0 %h",
               a_o_chan, a_o_data, D0);
    end
  endtask

  initial begin
    test_reset();
    test_explicit_select();
    test_stall();
    test_rr_fairness();
    test_flush();
    test_wrap_n3();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
